csa_serial_adder_ctrl: RTL
==========================

# csa_serial_adder_ctrl

Sequencer that adds two wide operands by time-multiplexing a single 8-bit carry-skip adder over consecutive cycles. The block accepts one operation over a valid/ready input handshake and feeds one 8-bit chunk per cycle, least-significant chunk first, through the shared adder. It latches the carry between passes and presents the full sum and carry-out over a valid/ready output handshake. It sits between an operand source (register file or DMA front end) and a result consumer, so a narrow adder can serve wide arithmetic.

## Interface
- WORDS, default 4: number of 8-bit chunks per operand, ≥1; operand width W = 8*WORDS
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  W  operand A, sampled on accept
- b  in  W  operand B, sampled on accept
- cin  in  1  carry-in, sampled on accept
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  W  registered sum
- cout  out  1  registered carry-out of the top chunk
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture a, b, cin into operand registers, set idx=0 and carry=cin, and go to RUN. While idle, sum and cout hold their previous values.
- RUN: drive the adder with a[8*idx+:8], b[8*idx+:8], and carry. Write the adder sum into sum[8*idx+:8] and the adder carry into carry.
  - If idx==WORDS-1: set cout to the adder carry and go to DONE.
  - Otherwise: idx=idx+1.
- DONE: out_valid=1. sum and cout hold steady. On out_ready, go to IDLE.
- Inputs during RUN/DONE are ignored. in_valid is not queued.
- idx width: clog2(WORDS), minimum 1 bit. idx never wraps past WORDS-1.
- Arithmetic is unsigned modulo 2^W. cout is bit W of a+b+cin.
- Adder per 4-bit group:
  - bit propagate p=a^b, generate g=a&b
  - ripple carry inside the group
  - group carry-out = cin_group when all four p are set, otherwise the rippled carry
  - functionally identical to a+b+cin

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry=0, idx=0.
- Reset mid-operation: the operation is abandoned. No out_valid is produced, and all registers return to their reset values immediately.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge.
- Throughput: at most one operation per WORDS+2 cycles. in_ready returns one cycle after the out_valid&out_ready edge.
- out_ready held low stalls DONE indefinitely. Outputs do not change during the stall.
- WORDS=1: one RUN cycle, then DONE.
- Adder path is combinational within one cycle. All outputs are registered; there are no combinational in→out paths.

## Structure
- Package csa_pkg holds:
  - CHUNK_W=8
  - state enum {IDLE, RUN, DONE}
- Sub-module csa8: purely combinational 8-bit carry-skip adder (two 4-bit skip groups). Ports: a, b, cin, sum, cout.
  - Instantiated once in the controller.
  - Independently testable against a+b+cin.

## Test plan
All cases use WORDS=4.
- Reset: assert rst asynchronously mid-cycle → in_ready=1, out_valid=0, busy=0, sum=0, cout=0 immediately.
- a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0, out_valid exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1. Exercises full skip chain across all chunks.
- a=0x80000000, b=0x80000000, cin=0, out_ready low for 3 cycles in DONE → sum=0, cout=1 stable. in_ready=0, and an in_valid pulse during the stall is ignored.
- Assert rst during RUN (idx=2) → IDLE next, no out_valid. A following op a=1, b=2 → sum=3, cout=0.
- Back-to-back ops with out_ready=1 and in_valid held → accepts spaced 6 cycles apart. Random a/b/cin sweep of 1000 ops matches a+b+cin.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the serial carry-skip adder sequencer.
//   CHUNK_W   : width of the shared adder slice
//   state_t   : controller states
//   idx_width : width of the chunk index for a given chunk count (min 1 bit)
package csa_pkg;

    localparam int unsigned CHUNK_W = 8;
    localparam int unsigned GROUP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/csa_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for csa_serial_adder_ctrl.
//   master : operand source / result consumer side
//   slave  : the sequencer side
//   in_valid/in_ready/a/b/cin     : operation request
//   out_valid/out_ready/sum/cout  : result delivery
//   busy                          : sequencer occupied (RUN or DONE)
interface csa_serial_adder_ctrl_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = csa_pkg::CHUNK_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/csa8.sv
// Purely combinational 8-bit carry-skip adder built from two 4-bit groups.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 8 bits
//   cout : carry out of bit 7
module csa8
    import csa_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout
);

    localparam int unsigned N_GROUPS = CHUNK_W / GROUP_W;

    logic [CHUNK_W-1:0] p;
    logic [CHUNK_W-1:0] gen;
    logic               carry;
    logic               grp_cin;

    // Ripple within each group; a fully-propagating group forwards its
    // incoming carry directly, which is the skip path.
    always_comb begin
        p       = a ^ b;
        gen     = a & b;
        sum     = '0;
        carry   = cin;
        grp_cin = cin;
        for (int grp = 0; grp < int'(N_GROUPS); grp++) begin
            grp_cin = carry;
            for (int i = 0; i < int'(GROUP_W); i++) begin
                sum[grp*GROUP_W + i] = p[grp*GROUP_W + i] ^ carry;
                carry = gen[grp*GROUP_W + i] | (p[grp*GROUP_W + i] & carry);
            end
            if (&p[grp*GROUP_W +: GROUP_W]) begin
                carry = grp_cin;
            end
        end
        cout = carry;
    end

endmodule

// File: rtl/csa_serial_adder_ctrl.sv
// Adds two WORDS*8-bit operands by passing one 8-bit chunk per cycle,
// least-significant first, through a single shared csa8 instance.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of csa_serial_adder_ctrl_if
//              (in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy)
// Every output is a flop; nothing on the bus is combinationally derived
// from a bus input.
module csa_serial_adder_ctrl
    import csa_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    csa_serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned W     = CHUNK_W * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_t state_q;
    state_t state_d;

    logic [W-1:0]     op_a_q;
    logic [W-1:0]     op_b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [IDX_W-1:0] idx_q;

    logic in_ready_q;
    logic out_valid_q;
    logic busy_q;
    logic in_ready_d;
    logic out_valid_d;
    logic busy_d;

    logic [CHUNK_W-1:0] add_a;
    logic [CHUNK_W-1:0] add_b;
    logic [CHUNK_W-1:0] add_sum;
    logic               add_cout;

    logic accept;
    logic last_chunk;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (idx_q == IDX_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = RUN;
            RUN:  if (last_chunk)    state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the flags register in step with it
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            RUN:     busy_d      = 1'b1;
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d  = 1'b1;
        endcase
    end

    // Handshake flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Select the current chunk of each operand for the shared adder
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                add_a = op_a_q[i*CHUNK_W +: CHUNK_W];
                add_b = op_b_q[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    csa8 u_csa8 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Operand capture, chunk sequencing and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < int'(WORDS); i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[i*CHUNK_W +: CHUNK_W] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (last_chunk) begin
                        cout_q <= add_cout;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule
